// File: rtl/pipe_stage_slice.sv
// rtl/pipe_stage_slice.sv - valid/ready pipeline stage register with flush, bubble clearing and stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_slice #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic in_xfer;
  assign in_xfer = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;

  assign in_ready = ready_q;

  // The skid entry can only be occupied while main is occupied, so main is
  // always refilled from skid before any new upstream beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else if (out_valid) begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
      ready_q    <= 1'b0;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end
`endif

  // Saturating count of held-but-not-taken cycles; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
